// File: rtl/cpu_mem_router.sv
// CPU-side memory router: decodes each CPU access into RAM, ROM, banked-ROM or
// peripheral space and runs the SDRAM req/ack handshake with a bounded wait.
module cpu_mem_router #(
    parameter int unsigned      ADDR_W      = 20,
    parameter int unsigned      SDR_W       = 25,
    parameter int unsigned      N_WIN       = 4,
    parameter int unsigned      IDX_W       = $clog2(N_WIN),
    parameter int unsigned      BANK_W      = 4,
    parameter int unsigned      WIN_PAGE    = 'hA,
    parameter int unsigned      RAM_PAGE    = 'hE,
    parameter int unsigned      PERIPH_PAGE = 'hF,
    parameter logic [SDR_W-1:0] ROM_BASE    = 25'h000000,
    parameter logic [SDR_W-1:0] RAM_BASE    = 25'h100000,
    parameter int unsigned      TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic [15:0]       cpu_rdata,
    input  logic              bank_wr,
    input  logic [IDX_W-1:0]  bank_idx,
    input  logic [BANK_W-1:0] bank_data,
    output logic              periph_sel,
    output logic              ro_violation,
    output logic              timeout_err,
    output logic              sdr_req,
    output logic              sdr_we,
    output logic [SDR_W-1:0]  sdr_addr,
    output logic [15:0]       sdr_wdata,
    input  logic              sdr_ack,
    input  logic [15:0]       sdr_rdata
);

    localparam int unsigned       PAGE_W   = ADDR_W - 16;
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [PAGE_W-1:0] WIN_P    = PAGE_W'(WIN_PAGE);
    localparam logic [PAGE_W-1:0] RAM_P    = PAGE_W'(RAM_PAGE);
    localparam logic [PAGE_W-1:0] PERIPH_P = PAGE_W'(PERIPH_PAGE);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SDR_WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic [15:0]        cpu_rdata_q, cpu_rdata_d;
    logic               periph_sel_q, periph_sel_d;
    logic               ro_violation_q, ro_violation_d;
    logic               timeout_err_q, timeout_err_d;
    logic               sdr_req_q, sdr_req_d;
    logic               sdr_we_q, sdr_we_d;
    logic [SDR_W-1:0]   sdr_addr_q, sdr_addr_d;
    logic [15:0]        sdr_wdata_q, sdr_wdata_d;
    logic [BANK_W-1:0]  bank_q [N_WIN];

    logic [PAGE_W-1:0]  page;
    logic [15:0]        off;
    logic [PAGE_W-1:0]  win_off;
    logic               in_win;
    logic [BANK_W-1:0]  win_bank;
    logic [SDR_W-1:0]   dec_addr;

    // Bank registers; an index with no matching register is simply dropped.
    for (genvar gi = 0; gi < N_WIN; gi++) begin : g_bank
        logic [BANK_W-1:0] bank_d;

        always_comb begin
            bank_d = bank_q[gi];
            if (bank_wr && bank_idx == IDX_W'(gi)) begin
                bank_d = bank_data;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                bank_q[gi] <= '0;
            end else begin
                bank_q[gi] <= bank_d;
            end
        end
    end

    assign page     = cpu_addr[ADDR_W-1:16];
    assign off      = cpu_addr[15:0];
    assign win_off  = page - WIN_P;
    assign in_win   = (page >= WIN_P) && (32'(win_off) < N_WIN);
    assign win_bank = bank_q[win_off[IDX_W-1:0]];

    always_comb begin
        if (page == RAM_P) begin
            dec_addr = RAM_BASE + SDR_W'(off);
        end else if (in_win) begin
            dec_addr = ROM_BASE + SDR_W'({win_bank, off});
        end else begin
            dec_addr = ROM_BASE + SDR_W'({page, off});
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cpu_ready_d    = 1'b0;
        cpu_rdata_d    = cpu_rdata_q;
        periph_sel_d   = 1'b0;
        ro_violation_d = 1'b0;
        timeout_err_d  = 1'b0;
        sdr_req_d      = sdr_req_q;
        sdr_we_d       = sdr_we_q;
        sdr_addr_d     = sdr_addr_q;
        sdr_wdata_d    = sdr_wdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (page == PERIPH_P) begin
                        periph_sel_d = 1'b1;
                        cpu_rdata_d  = 16'h0000;
                        state_d      = DONE;
                    end else if (page == RAM_P || !cpu_we) begin
                        sdr_req_d   = 1'b1;
                        sdr_we_d    = cpu_we;
                        sdr_addr_d  = dec_addr;
                        sdr_wdata_d = cpu_wdata;
                        cnt_d       = CNT_W'(1);
                        state_d     = SDR_WAIT;
                    end else begin
                        ro_violation_d = 1'b1;
                        cpu_rdata_d    = 16'h0000;
                        state_d        = DONE;
                    end
                end
            end
            SDR_WAIT: begin
                // cnt_q holds the number of cycles sdr_req has been high; ack beats the limit.
                if (sdr_ack) begin
                    sdr_req_d   = 1'b0;
                    cpu_rdata_d = sdr_rdata;
                    cpu_ready_d = 1'b1;
                    state_d     = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    sdr_req_d     = 1'b0;
                    cpu_rdata_d   = 16'hFFFF;
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Paths that enter without cpu_ready spend one cycle raising it here.
                if (cpu_ready_q) begin
                    state_d = IDLE;
                end else begin
                    cpu_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cpu_ready_q    <= 1'b0;
            cpu_rdata_q    <= '0;
            periph_sel_q   <= 1'b0;
            ro_violation_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            sdr_req_q      <= 1'b0;
            sdr_we_q       <= 1'b0;
            sdr_addr_q     <= '0;
            sdr_wdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cpu_ready_q    <= cpu_ready_d;
            cpu_rdata_q    <= cpu_rdata_d;
            periph_sel_q   <= periph_sel_d;
            ro_violation_q <= ro_violation_d;
            timeout_err_q  <= timeout_err_d;
            sdr_req_q      <= sdr_req_d;
            sdr_we_q       <= sdr_we_d;
            sdr_addr_q     <= sdr_addr_d;
            sdr_wdata_q    <= sdr_wdata_d;
        end
    end

    assign cpu_ready    = cpu_ready_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign periph_sel   = periph_sel_q;
    assign ro_violation = ro_violation_q;
    assign timeout_err  = timeout_err_q;
    assign sdr_req      = sdr_req_q;
    assign sdr_we       = sdr_we_q;
    assign sdr_addr     = sdr_addr_q;
    assign sdr_wdata    = sdr_wdata_q;

endmodule

// File: tb/tb_cpu_mem_router.sv
// Scoreboard bench for cpu_mem_router: each directed access queues its expected
// output events with cycle numbers; a negedge monitor pops and compares them.
module tb_cpu_mem_router;

    localparam int TO = 8;
    localparam int K_SDR = 0, K_PER = 1, K_ROV = 2;
    localparam int EV_REQ = 0, EV_DROP = 1, EV_RDY = 2, EV_TOE = 3, EV_PSEL = 4, EV_ROV = 5;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] val;
        logic [63:0] mask;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [19:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        bank_wr = 1'b0;
    logic [1:0]  bank_idx = '0;
    logic [3:0]  bank_data = '0;
    logic        periph_sel;
    logic        ro_violation;
    logic        timeout_err;
    logic        sdr_req;
    logic        sdr_we;
    logic [24:0] sdr_addr;
    logic [15:0] sdr_wdata;
    logic        sdr_ack = 1'b0;
    logic [15:0] sdr_rdata = '0;

    ev_t         exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        req_prev = 1'b0;
    logic [63:0] req_hold = '0;
    logic [63:0] req_now;

    cpu_mem_router #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .bank_wr(bank_wr), .bank_idx(bank_idx), .bank_data(bank_data),
        .periph_sel(periph_sel), .ro_violation(ro_violation), .timeout_err(timeout_err),
        .sdr_req(sdr_req), .sdr_we(sdr_we), .sdr_addr(sdr_addr), .sdr_wdata(sdr_wdata),
        .sdr_ack(sdr_ack), .sdr_rdata(sdr_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_REQ:  return "sdr_req_rise";
            EV_DROP: return "sdr_req_fall";
            EV_RDY:  return "cpu_ready";
            EV_TOE:  return "timeout_err";
            EV_PSEL: return "periph_sel";
            default: return "ro_violation";
        endcase
    endfunction

    task automatic push(input int k, input int c, input logic [63:0] v, input logic [63:0] m);
        ev_t e;
        e.kind = k; e.cyc = c; e.val = v; e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input logic [63:0] v);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected %s at cyc %0d got val %h, required no event", ev_name(k), cyc, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || ((v ^ e.val) & e.mask) != 64'h0) begin
                miscompares++;
                $display("FAIL event got %s cyc %0d val %h, required %s cyc %0d val %h",
                         ev_name(k), cyc, v, ev_name(e.kind), e.cyc, e.val & e.mask);
            end else begin
                $display("ok   %s cyc %0d val %h", ev_name(k), cyc, v);
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    // Monitor: event-driven comparison against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            req_now = {22'h0, sdr_we, sdr_addr, sdr_wdata};
            if (sdr_req && !req_prev) begin
                check_ev(EV_REQ, req_now);
                req_hold = req_now;
            end else if (sdr_req) begin
                vectors++;
                if (req_now != req_hold) begin
                    miscompares++;
                    $display("FAIL sdr_hold cyc %0d got %h required %h", cyc, req_now, req_hold);
                end
            end
            if (!sdr_req && req_prev) check_ev(EV_DROP, 64'h0);
            if (cpu_ready)    check_ev(EV_RDY, {48'h0, cpu_rdata});
            if (timeout_err)  check_ev(EV_TOE, 64'h0);
            if (periph_sel)   check_ev(EV_PSEL, 64'h0);
            if (ro_violation) check_ev(EV_ROV, 64'h0);
            req_prev = sdr_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic bank_write(input logic [1:0] idx, input logic [3:0] d);
        bank_wr = 1'b1; bank_idx = idx; bank_data = d;
        @(posedge clk); #1;
        bank_wr = 1'b0;
    endtask

    // One CPU access, entered and left #1 after a posedge. ack_at/bw_at are cycle
    // numbers relative to the sampling edge (cycle 0 = request cycle, -1 = never).
    task automatic access(input logic we, input logic [19:0] addr, input logic [15:0] wd,
                          input int kind, input logic [24:0] e_addr, input logic [15:0] e_rdata,
                          input int ack_at, input int bw_at, input logic [1:0] bw_idx,
                          input logic [3:0] bw_d);
        int t0;
        bit done;
        t0 = cyc;
        if (kind == K_SDR) begin
            push(EV_REQ, t0 + 1, {22'h0, we, e_addr, wd}, ALL);
            if (ack_at > 0) begin
                push(EV_DROP, t0 + ack_at + 1, 64'h0, ALL);
                push(EV_RDY, t0 + ack_at + 1, {48'h0, e_rdata}, ALL);
            end else begin
                push(EV_DROP, t0 + TO + 1, 64'h0, ALL);
                push(EV_TOE, t0 + TO + 1, 64'h0, ALL);
                push(EV_RDY, t0 + TO + 2, {48'h0, e_rdata}, ALL);
            end
        end else if (kind == K_PER) begin
            push(EV_PSEL, t0 + 1, 64'h0, ALL);
            push(EV_RDY, t0 + 2, {48'h0, e_rdata}, ALL);
        end else begin
            push(EV_ROV, t0 + 1, 64'h0, ALL);
            push(EV_RDY, t0 + 2, 64'h0, 64'h0);
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        bank_wr = (bw_at == 0); bank_idx = bw_idx; bank_data = bw_d;
        done = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(posedge clk); #1;
            bank_wr   = (bw_at == n);
            sdr_ack   = (ack_at == n);
            sdr_rdata = (ack_at == n) ? e_rdata : 16'h0000;
            if (cpu_ready) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_wait addr %h got no cpu_ready in 40 cycles, required one", addr);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; sdr_ack = 1'b0; bank_wr = 1'b0;
    endtask

    initial begin
        int t0;
        ev_t e;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sdr_req", {63'h0, sdr_req}, 64'h0);
        chk("rst_cpu_ready", {63'h0, cpu_ready}, 64'h0);
        chk("rst_cpu_rdata", {48'h0, cpu_rdata}, 64'h0);
        chk("rst_sdr_addr", {39'h0, sdr_addr}, 64'h0);
        chk("rst_flags", {61'h0, periph_sel, ro_violation, timeout_err}, 64'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 20'hE1234, 16'h0000, K_SDR, 25'h101234, 16'hBEEF, 3, -1, 2'd0, 4'h0);
        access(1'b1, 20'hE0002, 16'hA5A5, K_SDR, 25'h100002, 16'h0042, 1, -1, 2'd0, 4'h0);
        bank_write(2'd1, 4'h7);
        access(1'b0, 20'hB0010, 16'h0000, K_SDR, 25'h070010, 16'h1111, 2, -1, 2'd0, 4'h0);
        access(1'b0, 20'hC0010, 16'h0000, K_SDR, 25'h000010, 16'h2222, 2, 0, 2'd2, 4'h5);
        access(1'b0, 20'hC0010, 16'h0000, K_SDR, 25'h050010, 16'h3333, 1, -1, 2'd0, 4'h0);
        access(1'b0, 20'hB0010, 16'h0000, K_SDR, 25'h070010, 16'h4444, 4, 2, 2'd1, 4'h3);
        access(1'b0, 20'h12345, 16'h0000, K_SDR, 25'h012345, 16'h5555, 2, -1, 2'd0, 4'h0);
        access(1'b1, 20'h12345, 16'hDEAD, K_ROV, 25'h0, 16'h0, -1, -1, 2'd0, 4'h0);
        access(1'b1, 20'hB0000, 16'h0001, K_ROV, 25'h0, 16'h0, -1, -1, 2'd0, 4'h0);
        access(1'b0, 20'hF9800, 16'h0000, K_PER, 25'h0, 16'h0000, -1, -1, 2'd0, 4'h0);
        access(1'b0, 20'hE0000, 16'h0000, K_SDR, 25'h100000, 16'hFFFF, -1, -1, 2'd0, 4'h0);
        access(1'b1, 20'hF0000, 16'h7777, K_PER, 25'h0, 16'h0000, -1, -1, 2'd0, 4'h0);
        access(1'b0, 20'hE0004, 16'h0000, K_SDR, 25'h100004, 16'h6666, 8, -1, 2'd0, 4'h0);

        // Reset asserted in cycle 2 of SDR_WAIT; the later ack must be ignored.
        t0 = cyc;
        push(EV_REQ, t0 + 1, {22'h0, 1'b0, 25'h100100, 16'h0}, ALL);
        push(EV_DROP, t0 + 2, 64'h0, ALL);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'hE0100; cpu_wdata = 16'h0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset_n = 1'b0; cpu_req = 1'b0;
        #1;
        chk("mid_rst_sdr_req", {63'h0, sdr_req}, 64'h0);
        chk("mid_rst_cpu_ready", {63'h0, cpu_ready}, 64'h0);
        chk("mid_rst_sdr_addr", {39'h0, sdr_addr}, 64'h0);
        chk("mid_rst_cpu_rdata", {48'h0, cpu_rdata}, 64'h0);
        chk("mid_rst_flags", {61'h0, periph_sel, ro_violation, timeout_err}, 64'h0);
        @(posedge clk); #1;
        sdr_ack = 1'b1; sdr_rdata = 16'h9999;
        @(posedge clk); #1;
        sdr_ack = 1'b0; sdr_rdata = 16'h0; reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        access(1'b0, 20'hB0010, 16'h0000, K_SDR, 25'h000010, 16'h8888, 2, -1, 2'd0, 4'h0);
        access(1'b0, 20'hE1234, 16'h0000, K_SDR, 25'h101234, 16'hCAFE, 1, -1, 2'd0, 4'h0);

        repeat (5) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing %s got nothing, required at cyc %0d", ev_name(e.kind), e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
